// File: rtl/gpio_debounce.sv
// Purpose: per-bit 2-flop synchroniser and tick-sampled debounce filter, with optional rise/fall strobes (macro GPIO_DEBOUNCE_EDGE_EN).
// Latency: 2 sync cycles, then STABLE_CNT ticks of TICK_DIV cycles, then 1 register stage; no raw_in-to-output combinational path.
// Backpressure: none; free-running with no handshake, and all outputs are always valid.
module gpio_debounce #(
  parameter int WIDTH      = 16,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int PC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = ($clog2(STABLE_CNT + 1) > 1) ? $clog2(STABLE_CNT + 1) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             tick;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;

  // Two-stage synchroniser; only s2 feeds the filter.
  always_comb begin
    s1_d = raw_in;
    s2_d = s1_q;
  end

  // Free-running prescaler; tick marks the last cycle of each period and is never re-aligned to inputs.
  always_comb begin
    tick = (pc_q == PC_LAST);
    pc_d = tick ? '0 : pc_q + PC_W'(1);
  end

  // Per-bit filter: a level is accepted only after STABLE_CNT consecutive differing ticks.
  // Any agreeing tick discards the partial count, so cnt stays below STABLE_CNT.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s2_q[i] == db_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset clears everything so partial counts are lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      pc_q <= '0;
      db_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      pc_q <= pc_d;
      db_q <= db_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign db_out = db_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Edge detect on the next debounced value, so each strobe lands in the same cycle db_out changes.
  always_comb begin
    rise_d = db_d & ~db_q;
    fall_d = ~db_d & db_q;
  end

  // Strobe registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce (WIDTH=16, TICK_DIV=4, STABLE_CNT=3); follows GPIO_DEBOUNCE_EDGE_EN for strobe expectations.
// Reference model works from cycle index since reset, a 2-deep sample history and per-bit run lengths of differing ticks.
// Directed sequences, a vector table and randomized traffic are all compared against that model every cycle.
module tb_gpio_debounce;
  localparam int W  = 16;
  localparam int TD = 4;
  localparam int SC = 3;
`ifdef GPIO_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] db_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  gpio_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [W-1:0] m_db, m_rise, m_fall;
  int           m_run [W];
  int           m_k;
  logic [W-1:0] m_hist [$];

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] exp_db;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d at t=%0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic model_reset();
    m_db   = '0;
    m_rise = '0;
    m_fall = '0;
    m_k    = 0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_hist.delete();
    m_hist.push_back('0);
    m_hist.push_back('0);
  endtask

  // One clock edge: the sample two edges old is what the filter sees; a tick is the last cycle of each TD period.
  task automatic model_advance();
    logic [W-1:0] s2;
    logic [W-1:0] old;
    bit           tk;
    s2  = m_hist[0];
    old = m_db;
    tk  = ((m_k % TD) == TD - 1);
    if (tk) begin
      for (int i = 0; i < W; i++) begin
        if (s2[i] == old[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == SC) begin
            m_db[i]  = s2[i];
            m_run[i] = 0;
          end
        end
      end
    end
    m_rise = EDGE_EN ? (m_db & ~old) : '0;
    m_fall = EDGE_EN ? (~m_db & old) : '0;
    m_hist.push_back(raw_in);
    void'(m_hist.pop_front());
    m_k++;
  endtask

  // Drive on the falling edge, step the model on the rising edge, compare just after it.
  task automatic cyc(input logic [W-1:0] raw, input logic rst);
    @(negedge clock);
    raw_in = raw;
    reset  = rst;
    if (!rst) model_reset();
    @(posedge clock);
    if (rst) model_advance();
    #1;
    chk("db_out", db_out, m_db);
    chk("rise_pulse", rise_pulse, m_rise);
    chk("fall_pulse", fall_pulse, m_fall);
  endtask

  task automatic do_reset();
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    for (int i = 0; i < 3; i++) cyc('0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    bit found;
    logic [W-1:0] r;

    tbl[0] = '{raw: 16'h00F0, hold: 16, exp_db: 16'h00F0};
    tbl[1] = '{raw: 16'h00FF, hold: 3,  exp_db: 16'h00F0};
    tbl[2] = '{raw: 16'h0F0F, hold: 16, exp_db: 16'h0F0F};
    tbl[3] = '{raw: 16'hFFFF, hold: 16, exp_db: 16'hFFFF};
    tbl[4] = '{raw: 16'h0000, hold: 2,  exp_db: 16'hFFFF};
    tbl[5] = '{raw: 16'hFFFF, hold: 16, exp_db: 16'hFFFF};
    tbl[6] = '{raw: 16'h0000, hold: 16, exp_db: 16'h0000};

    reset  = 1'b0;
    raw_in = 16'hFFFF;
    model_reset();

    // Reset values with all inputs high, then release.
    for (int i = 0; i < 5; i++) cyc(16'hFFFF, 1'b0);
    chk("reset_db", db_out, 16'h0000);
    chk("reset_rise", rise_pulse, 16'h0000);
    chk("reset_fall", fall_pulse, 16'h0000);
    found = 0; lat = -1; cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc(16'hFFFF, 1'b1);
      if (rise_pulse == 16'hFFFF) cnt++;
      if (!found && db_out == 16'hFFFF) begin found = 1; lat = n; end
    end
    chk_rng("release_latency", lat, 11, 15);
    chk_rng("release_rise_cycles", cnt, EDGE_EN ? 1 : 0, EDGE_EN ? 1 : 0);

    // Step input on bit 0.
    do_reset();
    found = 0; lat = -1;
    for (int n = 1; n <= 20; n++) begin
      cyc(16'h0001, 1'b1);
      if (!found && db_out == 16'h0001) begin found = 1; lat = n; end
    end
    chk_rng("step_latency", lat, 11, 15);
    chk("step_db", db_out, 16'h0001);

    // Glitch on bit 3: 8 cycles high cannot cover 3 ticks.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(16'h0008, 1'b1);
    for (int i = 0; i < 8; i++) cyc(16'h0000, 1'b1);
    chk("glitch_db", db_out, 16'h0000);
    chk("glitch_cnt3", 16'(dut.cnt_q[3]), 16'h0000);

    // Independent channels: bit 7 high for one tick period mid-count.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(16'h8001, 1'b1);
    for (int i = 0; i < 4; i++) cyc(16'h8081, 1'b1);
    for (int i = 0; i < 20; i++) cyc(16'h8001, 1'b1);
    chk("indep_db", db_out, 16'h8001);

    // Fall strobe from db_out=0x0001.
    for (int i = 0; i < 20; i++) cyc(16'h0001, 1'b1);
    chk("fall_setup_db", db_out, 16'h0001);
    found = 0;
    for (int n = 1; n <= 20 && !found; n++) begin
      cyc(16'h0000, 1'b1);
      if (db_out == 16'h0000) begin
        found = 1;
        chk("fall_coincident", fall_pulse, EDGE_EN ? 16'h0001 : 16'h0000);
        chk("fall_no_rise", rise_pulse, 16'h0000);
        cyc(16'h0000, 1'b1);
        chk("fall_one_cycle", fall_pulse, 16'h0000);
      end
    end
    chk_rng("fall_found", int'(found), 1, 1);

    // Reset mid-count on bit 4 after two differing ticks.
    do_reset();
    found = 0;
    for (int n = 1; n <= 20 && !found; n++) begin
      cyc(16'h0010, 1'b1);
      if (m_run[4] == 2) found = 1;
    end
    chk_rng("midcount_reached", int'(found), 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(16'h0010, 1'b0);
      chk("midcount_reset_db", db_out, 16'h0000);
    end
    found = 0; lat = -1; cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      cyc(16'h0010, 1'b1);
      if (!EDGE_EN && (rise_pulse != 0 || fall_pulse != 0)) cnt++;
      if (!found && db_out[4]) begin found = 1; lat = n; end
    end
    chk_rng("midcount_latency", lat, 11, 30);
    chk_rng("midcount_strobes_off", cnt, 0, 0);

    // Vector table.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < tbl[v].hold; i++) cyc(tbl[v].raw, 1'b1);
      chk($sformatf("table_%0d", v), db_out, tbl[v].exp_db);
    end

    // Randomized traffic: sparse bit flips, short glitches and occasional resets.
    r = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 31) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 499) == 0) begin
        cyc(r, 1'b0);
        if ($urandom_range(0, 1) == 1) cyc(r, 1'b0);
      end else begin
        cyc(r, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
